// File: rtl/axi_isolate_pkg.sv
// Shared types for the AXI isolation controller: FSM states, counter sizing
// and a default narrow AXI4 request/response pair for the type parameters.
// No logic; imported by axi_isolate_cnt and axi_isolate_ctrl.
package axi_isolate_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2
  } state_e;

  // Width able to hold 0..max_txns inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_txns);
    return (max_txns < 1) ? 1 : $clog2(max_txns + 1);
  endfunction

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } ax_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
  } w_chan_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_resp_t;

endpackage

// File: rtl/axi_isolate_cnt.sv
// Outstanding-transaction up/down counter, saturating at 0 and MaxTxns.
// Latency: full_o/empty_o reflect the registered count (one cycle after inc/dec).
// Backpressure: none itself; the owner stalls increments using full_o.
// Ports: clk_i, rst_i (async, active-high), inc_i, dec_i, full_o, empty_o.
module axi_isolate_cnt
  import axi_isolate_pkg::*;
#(
  parameter int unsigned MaxTxns = 8,
  parameter int unsigned CntW    = cnt_w(MaxTxns)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [CntW-1:0] cnt_q;

  assign full_o  = (cnt_q == CntW'(MaxTxns));
  assign empty_o = (cnt_q == '0);

  // Simultaneous inc and dec cancel out; both ends hold instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i && !full_o) begin
      cnt_q <= cnt_q + CntW'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && !inc_i && empty_o));

endmodule

// File: rtl/axi_isolate_ctrl.sv
// Isolation sequencer for an AXI4 cut: blocks new AW/AR, drains in-flight
// transactions, then reports quiescence on isolated_o (registered).
// Latency: zero on the datapath; backpressure by gating valid/ready only.
// Ports: clk_i, rst_i (async, active-high), isolate_i (level), isolated_o,
//        slv_req_i/slv_resp_o (upstream), mst_req_o/mst_resp_i (towards cut).
module axi_isolate_ctrl
  import axi_isolate_pkg::*;
#(
  parameter int unsigned MaxTxns = 8,
  parameter type         req_t   = axi_req_t,
  parameter type         resp_t  = axi_resp_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  isolate_i,
  output logic  isolated_o,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o,
  output req_t  mst_req_o,
  input  resp_t mst_resp_i
);

  state_e state_q;
  logic   aw_hold_q, ar_hold_q;
  logic   wr_full, wr_empty, ww_full, ww_empty, rd_full, rd_empty;
  logic   aw_allow, ar_allow, w_allow;
  logic   aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;
  logic   drained;

  // A hold flag keeps an already-presented AW/AR forwarded regardless of
  // state or count, so a valid is never withdrawn downstream. wr_w never
  // exceeds wr_cnt with well-formed traffic; checking it too keeps that
  // counter from ever saturating.
  assign aw_allow = ((state_q == RUN) && !wr_full && !ww_full) || aw_hold_q;
  assign ar_allow = ((state_q == RUN) && !rd_full) || ar_hold_q;
  // Outside RUN, W only flows for AWs already forwarded; no W can leak ahead
  // of an AW that is being held back.
  assign w_allow  = (state_q == RUN) || !ww_empty;

  always_comb begin
    mst_req_o  = slv_req_i;
    slv_resp_o = mst_resp_i;
    mst_req_o.aw_valid  = slv_req_i.aw_valid  & aw_allow & ~rst_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_allow & ~rst_i;
    mst_req_o.w_valid   = slv_req_i.w_valid   & w_allow  & ~rst_i;
    slv_resp_o.w_ready  = mst_resp_i.w_ready  & w_allow  & ~rst_i;
    mst_req_o.ar_valid  = slv_req_i.ar_valid  & ar_allow & ~rst_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_allow & ~rst_i;
  end

  assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign w_last_hs = mst_req_o.w_valid & mst_resp_i.w_ready & mst_req_o.w.last;
  assign b_hs      = mst_resp_i.b_valid & mst_req_o.b_ready;
  assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign r_last_hs = mst_resp_i.r_valid & mst_req_o.r_ready & mst_resp_i.r.last;

  axi_isolate_cnt #(.MaxTxns(MaxTxns)) i_wr_cnt (
    .clk_i, .rst_i, .inc_i(aw_hs), .dec_i(b_hs),
    .full_o(wr_full), .empty_o(wr_empty)
  );

  axi_isolate_cnt #(.MaxTxns(MaxTxns)) i_wr_w (
    .clk_i, .rst_i, .inc_i(aw_hs), .dec_i(w_last_hs),
    .full_o(ww_full), .empty_o(ww_empty)
  );

  axi_isolate_cnt #(.MaxTxns(MaxTxns)) i_rd_cnt (
    .clk_i, .rst_i, .inc_i(ar_hs), .dec_i(r_last_hs),
    .full_o(rd_full), .empty_o(rd_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_hold_q <= 1'b0;
      ar_hold_q <= 1'b0;
    end else begin
      if (aw_hs)                   aw_hold_q <= 1'b0;
      else if (mst_req_o.aw_valid) aw_hold_q <= 1'b1;
      if (ar_hs)                   ar_hold_q <= 1'b0;
      else if (mst_req_o.ar_valid) ar_hold_q <= 1'b1;
    end
  end

  // Current counts empty plus no counting handshake this cycle means the
  // post-edge counts are also zero: nothing can still be in flight.
  assign drained = wr_empty & ww_empty & rd_empty & ~aw_hold_q & ~ar_hold_q &
                   ~(aw_hs | w_last_hs | b_hs | ar_hs | r_last_hs);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      isolated_o <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (isolate_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!isolate_i) begin
            state_q <= RUN;
          end else if (drained) begin
            state_q    <= ISOLATED;
            isolated_o <= 1'b1;
          end
        end
        ISOLATED: begin
          if (!isolate_i) begin
            state_q    <= RUN;
            isolated_o <= 1'b0;
          end
        end
        default: begin
          state_q    <= RUN;
          isolated_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_isolate_ctrl.sv
// Randomised bench for axi_isolate_ctrl: an upstream master and downstream
// slave model exchange traffic while isolate_i toggles; payloads go through a
// scoreboard and gating/isolated_o are checked each cycle against a model.
module tb_axi_isolate_ctrl;
  import axi_isolate_pkg::*;

  localparam int MAX    = 2;
  localparam int S_RUN  = 0;
  localparam int S_DRN  = 1;
  localparam int S_ISO  = 2;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      iso = 1'b0;
  logic      isolated;
  axi_req_t  slv_req, mst_req;
  axi_resp_t slv_resp, mst_resp;

  axi_isolate_ctrl #(.MaxTxns(MAX), .req_t(axi_req_t), .resp_t(axi_resp_t)) dut (
    .clk_i(clk), .rst_i(rst), .isolate_i(iso), .isolated_o(isolated),
    .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard queues: pushed when the bench issues, popped when the DUT
  // presents the corresponding handshake on the far side.
  ax_chan_t q_aw[$], q_ar[$];
  w_chan_t  q_w[$];
  b_chan_t  q_b[$];
  r_chan_t  q_r[$];

  // Stimulus-side bookkeeping.
  int          up_wq[$];
  int          up_wbeat;
  logic [3:0]  dn_awid[$];
  logic [3:0]  dn_bid[$];
  ax_chan_t    dn_rq[$];
  int          dn_rbeat;
  bit          up_en = 1'b0;
  bit          r_en  = 1'b1;

  // Handshakes seen at the negedge, consumed by the driver after the posedge.
  bit up_aw_hs, up_w_hs, up_ar_hs, dn_aw_hs, dn_w_hs, dn_ar_hs, dn_b_hs, dn_r_hs;
  bit dn_w_last;
  logic [3:0] cap_aw_id;
  ax_chan_t   cap_ar;
  int n_dn_aw = 0;
  int n_dn_ar = 0;

  // Reference model: outstanding-transaction arithmetic and isolation mode.
  int m_wr, m_ww, m_rd, m_st;
  bit m_awh, m_arh, m_iso;

  // Monitor
  initial begin : monitor
    bit aw_al, ar_al, w_al, aw_h, ar_h, w_lh, b_h, r_lh, any_h, nawh, narh;
    int nwr, nww, nrd;
    logic [9:0] act, exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_gating", 64'({mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                                 slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready}), 64'd0);
        chk("reset_isolated", 64'(isolated), 64'd0);
        m_wr = 0; m_ww = 0; m_rd = 0; m_st = S_RUN; m_awh = 0; m_arh = 0; m_iso = 0;
        {up_aw_hs, up_w_hs, up_ar_hs, dn_aw_hs, dn_w_hs, dn_ar_hs, dn_b_hs, dn_r_hs} = '0;
      end else begin
        aw_al = (m_st == S_RUN && m_wr < MAX) || m_awh;
        ar_al = (m_st == S_RUN && m_rd < MAX) || m_arh;
        w_al  = (m_st == S_RUN) || (m_ww > 0);
        exp = {slv_req.aw_valid & aw_al, mst_resp.aw_ready & aw_al,
               slv_req.w_valid & w_al,   mst_resp.w_ready & w_al,
               slv_req.ar_valid & ar_al, mst_resp.ar_ready & ar_al,
               mst_resp.b_valid, slv_req.b_ready, mst_resp.r_valid, slv_req.r_ready};
        act = {mst_req.aw_valid, slv_resp.aw_ready, mst_req.w_valid, slv_resp.w_ready,
               mst_req.ar_valid, slv_resp.ar_ready, slv_resp.b_valid, mst_req.b_ready,
               slv_resp.r_valid, mst_req.r_ready};
        chk("gating", 64'(act), 64'(exp));
        chk("isolated", 64'(isolated), 64'(m_iso));

        // Payload scoreboard on the side where the DUT presents the handshake.
        if (mst_req.aw_valid && mst_resp.aw_ready) begin
          n_dn_aw++;
          if (q_aw.size() == 0) begin
            checks++; errors++;
            $display("FAIL aw_payload: got forwarded AW %h expected none issued", mst_req.aw);
          end else chk("aw_payload", 64'(mst_req.aw), 64'(q_aw.pop_front()));
        end
        if (mst_req.w_valid && mst_resp.w_ready) begin
          if (q_w.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_payload: got forwarded W %h expected none issued", mst_req.w);
          end else chk("w_payload", 64'(mst_req.w), 64'(q_w.pop_front()));
        end
        if (mst_req.ar_valid && mst_resp.ar_ready) begin
          n_dn_ar++;
          if (q_ar.size() == 0) begin
            checks++; errors++;
            $display("FAIL ar_payload: got forwarded AR %h expected none issued", mst_req.ar);
          end else chk("ar_payload", 64'(mst_req.ar), 64'(q_ar.pop_front()));
        end
        if (slv_resp.b_valid && slv_req.b_ready) begin
          if (q_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_payload: got B %h expected none issued", slv_resp.b);
          end else chk("b_payload", 64'(slv_resp.b), 64'(q_b.pop_front()));
        end
        if (slv_resp.r_valid && slv_req.r_ready) begin
          if (q_r.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_payload: got R %h expected none issued", slv_resp.r);
          end else chk("r_payload", 64'(slv_resp.r), 64'(q_r.pop_front()));
        end

        // Observed handshakes for the stimulus process.
        up_aw_hs  = slv_req.aw_valid && slv_resp.aw_ready;
        up_w_hs   = slv_req.w_valid && slv_resp.w_ready;
        up_ar_hs  = slv_req.ar_valid && slv_resp.ar_ready;
        dn_aw_hs  = mst_req.aw_valid && mst_resp.aw_ready;
        dn_w_hs   = mst_req.w_valid && mst_resp.w_ready;
        dn_ar_hs  = mst_req.ar_valid && mst_resp.ar_ready;
        dn_b_hs   = mst_resp.b_valid && mst_req.b_ready;
        dn_r_hs   = mst_resp.r_valid && mst_req.r_ready;
        dn_w_last = mst_req.w.last;
        cap_aw_id = mst_req.aw.id;
        cap_ar    = mst_req.ar;

        // Model advance, driven only by bench inputs and model state.
        aw_h  = slv_req.aw_valid && aw_al && mst_resp.aw_ready;
        ar_h  = slv_req.ar_valid && ar_al && mst_resp.ar_ready;
        w_lh  = slv_req.w_valid && w_al && mst_resp.w_ready && slv_req.w.last;
        b_h   = mst_resp.b_valid && slv_req.b_ready;
        r_lh  = mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;
        any_h = aw_h || ar_h || w_lh || b_h || r_lh;
        nwr = m_wr + int'(aw_h) - int'(b_h);  if (nwr < 0) nwr = 0;
        nww = m_ww + int'(aw_h) - int'(w_lh); if (nww < 0) nww = 0;
        nrd = m_rd + int'(ar_h) - int'(r_lh); if (nrd < 0) nrd = 0;
        nawh = aw_h ? 1'b0 : ((slv_req.aw_valid && aw_al) ? 1'b1 : m_awh);
        narh = ar_h ? 1'b0 : ((slv_req.ar_valid && ar_al) ? 1'b1 : m_arh);
        if (m_st == S_RUN) begin
          if (iso) m_st = S_DRN;
        end else if (m_st == S_DRN) begin
          if (!iso) m_st = S_RUN;
          else if (nwr == 0 && nww == 0 && nrd == 0 && !nawh && !narh && !any_h) m_st = S_ISO;
        end else if (!iso) m_st = S_RUN;
        m_wr = nwr; m_ww = nww; m_rd = nrd; m_awh = nawh; m_arh = narh;
        m_iso = (m_st == S_ISO);
      end
    end
  end

  // Upstream master and downstream slave models.
  initial begin : driver
    slv_req  = '0;
    mst_resp = '0;
    up_wbeat = 0;
    dn_rbeat = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        slv_req = '0; mst_resp = '0; up_wbeat = 0; dn_rbeat = 0;
        q_aw.delete(); q_ar.delete(); q_w.delete(); q_b.delete(); q_r.delete();
        up_wq.delete(); dn_awid.delete(); dn_bid.delete(); dn_rq.delete();
      end else begin
        // upstream AW
        if (up_aw_hs) begin
          up_wq.push_back(int'(slv_req.aw.len));
          slv_req.aw_valid = 1'b0;
        end
        if (!slv_req.aw_valid && up_en && $urandom_range(0, 3) == 0) begin
          slv_req.aw.id   = 4'($urandom);
          slv_req.aw.addr = $urandom;
          slv_req.aw.len  = 8'($urandom_range(0, 3));
          slv_req.aw_valid = 1'b1;
          q_aw.push_back(slv_req.aw);
        end
        // upstream W, only for AWs already accepted
        if (up_w_hs) begin
          slv_req.w_valid = 1'b0;
          if (slv_req.w.last) begin
            void'(up_wq.pop_front());
            up_wbeat = 0;
          end else up_wbeat++;
        end
        if (!slv_req.w_valid && up_wq.size() > 0 && $urandom_range(0, 2) != 0) begin
          slv_req.w.data = $urandom;
          slv_req.w.strb = 4'($urandom);
          slv_req.w.last = (up_wbeat == up_wq[0]);
          slv_req.w_valid = 1'b1;
          q_w.push_back(slv_req.w);
        end
        // upstream AR
        if (up_ar_hs) slv_req.ar_valid = 1'b0;
        if (!slv_req.ar_valid && up_en && $urandom_range(0, 3) == 0) begin
          slv_req.ar.id   = 4'($urandom);
          slv_req.ar.addr = $urandom;
          slv_req.ar.len  = 8'($urandom_range(0, 3));
          slv_req.ar_valid = 1'b1;
          q_ar.push_back(slv_req.ar);
        end
        slv_req.b_ready = ($urandom_range(0, 3) != 0);
        slv_req.r_ready = ($urandom_range(0, 3) != 0);

        // downstream write side: B only after the AW's last W beat
        if (dn_aw_hs) dn_awid.push_back(cap_aw_id);
        if (dn_w_hs && dn_w_last && dn_awid.size() > 0) dn_bid.push_back(dn_awid.pop_front());
        if (dn_b_hs) mst_resp.b_valid = 1'b0;
        if (!mst_resp.b_valid && dn_bid.size() > 0 && $urandom_range(0, 2) == 0) begin
          mst_resp.b.id   = dn_bid.pop_front();
          mst_resp.b.resp = 2'($urandom);
          mst_resp.b_valid = 1'b1;
          q_b.push_back(mst_resp.b);
        end
        // downstream read side: len+1 beats per AR, in order
        if (dn_ar_hs) dn_rq.push_back(cap_ar);
        if (dn_r_hs) begin
          mst_resp.r_valid = 1'b0;
          if (mst_resp.r.last) begin
            if (dn_rq.size() > 0) void'(dn_rq.pop_front());
            dn_rbeat = 0;
          end else dn_rbeat++;
        end
        if (!mst_resp.r_valid && dn_rq.size() > 0 && r_en && $urandom_range(0, 2) != 0) begin
          mst_resp.r.id   = dn_rq[0].id;
          mst_resp.r.data = $urandom;
          mst_resp.r.resp = 2'($urandom);
          mst_resp.r.last = (dn_rbeat == int'(dn_rq[0].len));
          mst_resp.r_valid = 1'b1;
          q_r.push_back(mst_resp.r);
        end
        mst_resp.aw_ready = ($urandom_range(0, 2) == 0);
        mst_resp.w_ready  = ($urandom_range(0, 1) == 0);
        mst_resp.ar_ready = ($urandom_range(0, 2) == 0);
      end
    end
  end

  function automatic bit all_idle();
    return q_aw.size() == 0 && q_w.size() == 0 && q_ar.size() == 0 &&
           q_b.size() == 0 && q_r.size() == 0 && up_wq.size() == 0 &&
           dn_rq.size() == 0 && dn_bid.size() == 0 && dn_awid.size() == 0 &&
           !slv_req.aw_valid && !slv_req.w_valid && !slv_req.ar_valid &&
           !mst_resp.b_valid && !mst_resp.r_valid &&
           m_wr == 0 && m_ww == 0 && m_rd == 0;
  endfunction

  // Sequence
  initial begin : sequencer
    int base_aw, base_ar;
    bit done;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_isolated", 64'(isolated), 64'd0);

    // Idle isolate: DRAIN one edge after request, isolated on the next.
    repeat (8) @(posedge clk);
    #2 iso = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("idle_drain_isolated", 64'(isolated), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("idle_isolated", 64'(isolated), 64'd1);

    // New requests presented while isolated are never forwarded.
    base_aw = n_dn_aw; base_ar = n_dn_ar;
    @(posedge clk); #2 up_en = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("iso_blocked_aw_ar", 64'(n_dn_aw - base_aw + n_dn_ar - base_ar), 64'd0);
    chk("iso_still_isolated", 64'(isolated), 64'd1);
    @(posedge clk); #2 iso = 1'b0;

    // Random traffic with isolate toggling, read stalls and a mid-run reset.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 39) == 0) iso = ~iso;
      if ($urandom_range(0, 49) == 0) r_en = ~r_en;
      if (c == 2000) #1 rst = 1'b1;
      if (c == 2003) rst = 1'b0;
    end

    // Let everything complete, then a final isolation must succeed.
    iso = 1'b0; up_en = 1'b0; r_en = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      done = all_idle();
    end
    chk("drain_completes", 64'(done), 64'd1);
    @(posedge clk); #2 iso = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_isolated", 64'(isolated), 64'd1);
    @(posedge clk); #2 iso = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("final_reconnect", 64'(isolated), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
